// File: rtl/jtag_tap.sv
// JTAG TAP controller: the 16-state TAP FSM, instruction register, BYPASS, IDCODE
// and one user data register with a one-cycle update strobe.
module jtag_tap #(
    parameter int                  IR_WIDTH     = 4,
    parameter logic [31:0]         IDCODE       = 32'h1000_0001,
    parameter logic [IR_WIDTH-1:0] IDCODE_INSTR = IR_WIDTH'(4'b0001),
    parameter logic [IR_WIDTH-1:0] USER_INSTR   = IR_WIDTH'(4'b1000),
    parameter int                  USER_WIDTH   = 8
) (
    input  logic                  CLK,
    input  logic                  RESETN,
    input  logic                  tms,
    input  logic                  tdi,
    output logic                  tdo,
    output logic                  tdo_en,
    output logic [3:0]            state,
    output logic [IR_WIDTH-1:0]   ir,
    input  logic [USER_WIDTH-1:0] user_in,
    output logic [USER_WIDTH-1:0] user_out,
    output logic                  user_update
);

    typedef enum logic [3:0] {
        TLR    = 4'd15,
        RTI    = 4'd12,
        SEL_DR = 4'd7,
        CAP_DR = 4'd6,
        SH_DR  = 4'd2,
        EX1_DR = 4'd1,
        PAU_DR = 4'd3,
        EX2_DR = 4'd0,
        UPD_DR = 4'd5,
        SEL_IR = 4'd4,
        CAP_IR = 4'd14,
        SH_IR  = 4'd10,
        EX1_IR = 4'd9,
        PAU_IR = 4'd11,
        EX2_IR = 4'd8,
        UPD_IR = 4'd13
    } tap_state_t;

    typedef enum logic [1:0] {
        SEL_BYPASS,
        SEL_IDCODE,
        SEL_USER
    } dr_sel_t;

    tap_state_t            state_q;
    tap_state_t            state_d;
    dr_sel_t               dr_sel;
    logic [IR_WIDTH-1:0]   ir_sr;
    logic                  bypass;
    logic [31:0]           idcode_sr;
    logic [USER_WIDTH-1:0] user_sr;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, matching the "state before the edge" rule.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) state_q <= TLR;
        else         state_q <= state_d;
    end

    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:    state_d = tms ? TLR    : RTI;
            RTI:    state_d = tms ? SEL_DR : RTI;
            SEL_DR: state_d = tms ? SEL_IR : CAP_DR;
            CAP_DR: state_d = tms ? EX1_DR : SH_DR;
            SH_DR:  state_d = tms ? EX1_DR : SH_DR;
            EX1_DR: state_d = tms ? UPD_DR : PAU_DR;
            PAU_DR: state_d = tms ? EX2_DR : PAU_DR;
            EX2_DR: state_d = tms ? UPD_DR : SH_DR;
            UPD_DR: state_d = tms ? SEL_DR : RTI;
            SEL_IR: state_d = tms ? TLR    : CAP_IR;
            CAP_IR: state_d = tms ? EX1_IR : SH_IR;
            SH_IR:  state_d = tms ? EX1_IR : SH_IR;
            EX1_IR: state_d = tms ? UPD_IR : PAU_IR;
            PAU_IR: state_d = tms ? EX2_IR : PAU_IR;
            EX2_IR: state_d = tms ? UPD_IR : SH_IR;
            UPD_IR: state_d = tms ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase
    end

    // All-ones is BYPASS by definition; unknown opcodes also fall back to it.
    always_comb begin
        dr_sel = SEL_BYPASS;
        if (ir == '1)                dr_sel = SEL_BYPASS;
        else if (ir == IDCODE_INSTR) dr_sel = SEL_IDCODE;
        else if (ir == USER_INSTR)   dr_sel = SEL_USER;
    end

    // NOTE: every register here, including the shift registers, is reset so a
    // mid-scan reset leaves no partial state behind.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            ir          <= IDCODE_INSTR;
            ir_sr       <= '0;
            bypass      <= 1'b0;
            idcode_sr   <= IDCODE;
            user_sr     <= '0;
            user_out    <= '0;
            user_update <= 1'b0;
        end else begin
            user_update <= 1'b0;
            case (state_q)
                TLR:    ir    <= IDCODE_INSTR;
                CAP_IR: ir_sr <= IR_WIDTH'(2'b01);
                SH_IR:  ir_sr <= {tdi, ir_sr[IR_WIDTH-1:1]};
                UPD_IR: ir    <= ir_sr;
                CAP_DR: begin
                    case (dr_sel)
                        SEL_IDCODE: idcode_sr <= IDCODE;
                        SEL_USER:   user_sr   <= user_in;
                        default:    bypass    <= 1'b0;
                    endcase
                end
                SH_DR: begin
                    case (dr_sel)
                        SEL_IDCODE: idcode_sr <= {tdi, idcode_sr[31:1]};
                        // Shift form that also holds for a one-bit user DR.
                        SEL_USER:   user_sr   <= (user_sr >> 1) |
                                                 (USER_WIDTH'(tdi) << (USER_WIDTH - 1));
                        default:    bypass    <= tdi;
                    endcase
                end
                UPD_DR: begin
                    if (dr_sel == SEL_USER) begin
                        user_out    <= user_sr;
                        user_update <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        tdo = 1'b0;
        if (state_q == SH_IR) begin
            tdo = ir_sr[0];
        end else if (state_q == SH_DR) begin
            case (dr_sel)
                SEL_IDCODE: tdo = idcode_sr[0];
                SEL_USER:   tdo = user_sr[0];
                default:    tdo = bypass;
            endcase
        end
    end

    assign tdo_en = (state_q == SH_DR) || (state_q == SH_IR);
    assign state  = state_q;

endmodule

// File: tb/tb_jtag_tap.sv
// Self-checking bench for jtag_tap: directed scans followed by random TMS/TDI
// traffic compared every cycle against a table-driven reference model.
module tb_jtag_tap;

    localparam int          IR_WIDTH     = 4;
    localparam int          USER_WIDTH   = 8;
    localparam logic [31:0] IDCODE       = 32'h1000_0001;
    localparam logic [3:0]  IDCODE_INSTR = 4'b0001;
    localparam logic [3:0]  USER_INSTR   = 4'b1000;

    localparam int S_TLR = 15, S_RTI = 12;
    localparam int S_SELDR = 7, S_CAPDR = 6, S_SHDR = 2, S_EX1DR = 1;
    localparam int S_PAUDR = 3, S_EX2DR = 0, S_UPDDR = 5;
    localparam int S_SELIR = 4, S_CAPIR = 14, S_SHIR = 10, S_EX1IR = 9;
    localparam int S_PAUIR = 11, S_EX2IR = 8, S_UPDIR = 13;

    logic                  CLK = 1'b0;
    logic                  RESETN = 1'b0;
    logic                  tms = 1'b1;
    logic                  tdi = 1'b0;
    logic [USER_WIDTH-1:0] user_in = '0;
    logic                  tdo;
    logic                  tdo_en;
    logic [3:0]            state;
    logic [IR_WIDTH-1:0]   ir;
    logic [USER_WIDTH-1:0] user_out;
    logic                  user_update;

    jtag_tap #(
        .IR_WIDTH    (IR_WIDTH),
        .IDCODE      (IDCODE),
        .IDCODE_INSTR(IDCODE_INSTR),
        .USER_INSTR  (USER_INSTR),
        .USER_WIDTH  (USER_WIDTH)
    ) dut (
        .CLK        (CLK),
        .RESETN     (RESETN),
        .tms        (tms),
        .tdi        (tdi),
        .tdo        (tdo),
        .tdo_en     (tdo_en),
        .state      (state),
        .ir         (ir),
        .user_in    (user_in),
        .user_out   (user_out),
        .user_update(user_update)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Reference model: transition tables plus plain register values.
    int          nxt0 [16];
    int          nxt1 [16];
    int          m_state;
    logic [3:0]  m_ir;
    logic [3:0]  m_ir_sr;
    logic        m_bypass;
    logic [31:0] m_id;
    logic [7:0]  m_user_sr;
    logic [7:0]  m_user_out;
    logic        m_upd;
    logic        pre_tdo;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic link(input int s, input int on0, input int on1);
        nxt0[s] = on0;
        nxt1[s] = on1;
    endtask

    task automatic init_tables();
        link(S_TLR,   S_RTI,   S_TLR);
        link(S_RTI,   S_RTI,   S_SELDR);
        link(S_SELDR, S_CAPDR, S_SELIR);
        link(S_SELIR, S_CAPIR, S_TLR);
        link(S_CAPDR, S_SHDR,  S_EX1DR);
        link(S_SHDR,  S_SHDR,  S_EX1DR);
        link(S_EX1DR, S_PAUDR, S_UPDDR);
        link(S_PAUDR, S_PAUDR, S_EX2DR);
        link(S_EX2DR, S_SHDR,  S_UPDDR);
        link(S_UPDDR, S_RTI,   S_SELDR);
        link(S_CAPIR, S_SHIR,  S_EX1IR);
        link(S_SHIR,  S_SHIR,  S_EX1IR);
        link(S_EX1IR, S_PAUIR, S_UPDIR);
        link(S_PAUIR, S_PAUIR, S_EX2IR);
        link(S_EX2IR, S_SHIR,  S_UPDIR);
        link(S_UPDIR, S_RTI,   S_SELDR);
    endtask

    task automatic model_reset();
        m_state    = S_TLR;
        m_ir       = IDCODE_INSTR;
        m_ir_sr    = '0;
        m_bypass   = 1'b0;
        m_id       = IDCODE;
        m_user_sr  = '0;
        m_user_out = '0;
        m_upd      = 1'b0;
    endtask

    // 0 = bypass, 1 = idcode, 2 = user
    function automatic int m_sel();
        if (m_ir == 4'hF)              return 0;
        else if (m_ir == IDCODE_INSTR) return 1;
        else if (m_ir == USER_INSTR)   return 2;
        return 0;
    endfunction

    function automatic logic m_tdo_en();
        return (m_state == S_SHDR) || (m_state == S_SHIR);
    endfunction

    function automatic logic m_tdo();
        int sel;
        sel = m_sel();
        if (m_state == S_SHIR) return m_ir_sr[0];
        if (m_state == S_SHDR) begin
            if (sel == 1) return m_id[0];
            if (sel == 2) return m_user_sr[0];
            return m_bypass;
        end
        return 1'b0;
    endfunction

    task automatic model_step(input logic t_tms, input logic t_tdi, input logic [7:0] uin);
        int cur;
        int sel;
        cur   = m_state;
        sel   = m_sel();
        m_upd = 1'b0;
        if (cur == S_TLR)   m_ir = IDCODE_INSTR;
        if (cur == S_CAPIR) m_ir_sr = 4'b0001;
        if (cur == S_SHIR)  m_ir_sr = (m_ir_sr >> 1) | (t_tdi ? 4'b1000 : 4'b0000);
        if (cur == S_UPDIR) m_ir = m_ir_sr;
        if (cur == S_CAPDR) begin
            if (sel == 1)      m_id = IDCODE;
            else if (sel == 2) m_user_sr = uin;
            else               m_bypass = 1'b0;
        end
        if (cur == S_SHDR) begin
            if (sel == 1)      m_id = (m_id >> 1) | (t_tdi ? 32'h8000_0000 : 32'h0);
            else if (sel == 2) m_user_sr = (m_user_sr >> 1) | (t_tdi ? 8'h80 : 8'h00);
            else               m_bypass = t_tdi;
        end
        if (cur == S_UPDDR && sel == 2) begin
            m_user_out = m_user_sr;
            m_upd      = 1'b1;
        end
        m_state = t_tms ? nxt1[cur] : nxt0[cur];
    endtask

    task automatic compare_all(input string ctx);
        check({ctx, ".state"},       32'(state),       32'(m_state));
        check({ctx, ".tdo_en"},      32'(tdo_en),      32'(m_tdo_en()));
        check({ctx, ".tdo"},         32'(tdo),         32'(m_tdo()));
        check({ctx, ".ir"},          32'(ir),          32'(m_ir));
        check({ctx, ".user_out"},    32'(user_out),    32'(m_user_out));
        check({ctx, ".user_update"}, 32'(user_update), 32'(m_upd));
    endtask

    // One TCK cycle; pre_tdo holds tdo as seen just before the edge.
    task automatic tick(input logic t_tms, input logic t_tdi);
        pre_tdo = tdo;
        tms     = t_tms;
        tdi     = t_tdi;
        @(posedge CLK);
        model_step(t_tms, t_tdi, user_in);
        #1;
        compare_all("tick");
    endtask

    task automatic async_reset();
        #2;
        RESETN = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst");
        #1;
        RESETN = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] word;
        logic [3:0]  ir_bits;
        logic [2:0]  byp_bits;
        logic [7:0]  user_bits;
        logic [7:0]  pattern;
        logic [3:0]  opcode;

        init_tables();
        model_reset();

        // Reset state
        #12;
        check("rst.state",       32'(state),       32'd15);
        check("rst.ir",          32'(ir),          32'(IDCODE_INSTR));
        check("rst.tdo_en",      32'(tdo_en),      32'd0);
        check("rst.user_out",    32'(user_out),    32'd0);
        check("rst.user_update", 32'(user_update), 32'd0);
        compare_all("rst");
        RESETN = 1'b1;
        tick(1'b0, 1'b0);
        check("tlr_to_rti", 32'(state), 32'd12);

        // Shift-DR then five tms=1 back to TLR
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        check("at_shdr", 32'(state), 32'd2);
        tick(1'b1, 1'b0); check("tms1_1", 32'(state), 32'd1);
        tick(1'b1, 1'b0); check("tms1_2", 32'(state), 32'd5);
        tick(1'b1, 1'b0); check("tms1_3", 32'(state), 32'd7);
        tick(1'b1, 1'b0); check("tms1_4", 32'(state), 32'd4);
        tick(1'b1, 1'b0); check("tms1_5", 32'(state), 32'd15);

        // IDCODE read
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        word = '0;
        for (int i = 0; i < 32; i++) begin
            tick(i == 31, 1'b0);
            word[i] = pre_tdo;
        end
        check("idcode_read", word, 32'h1000_0001);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);

        // IR scan of all ones -> BYPASS
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        ir_bits = '0;
        for (int i = 0; i < 4; i++) begin
            tick(i == 3, 1'b1);
            ir_bits[i] = pre_tdo;
        end
        check("ir_capture", 32'(ir_bits[1:0]), 32'b01);
        check("ir_mid_update", 32'(ir), 32'(IDCODE_INSTR));
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        check("ir_bypass", 32'(ir), 32'hF);

        // Bypass delay: tdi 1,0,1 -> tdo 0,1,0
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        pattern = 8'b0000_0101;
        byp_bits = '0;
        for (int i = 0; i < 3; i++) begin
            tick(i == 2, pattern[i]);
            byp_bits[i] = pre_tdo;
        end
        check("bypass_delay", 32'(byp_bits), 32'b010);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);

        // Reset in the middle of an IR shift
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        check("pre_rst_shir", 32'(state), 32'd10);
        async_reset();
        check("midshift_rst.state",    32'(state),    32'd15);
        check("midshift_rst.ir",       32'(ir),       32'(IDCODE_INSTR));
        check("midshift_rst.user_out", 32'(user_out), 32'd0);

        // Load USER_INSTR
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        opcode = USER_INSTR;
        for (int i = 0; i < 4; i++) tick(i == 3, opcode[i]);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        check("ir_user", 32'(ir), 32'(USER_INSTR));

        // User DR: capture 3C, shift in A5
        user_in = 8'h3C;
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        pattern = 8'hA5;
        user_bits = '0;
        for (int i = 0; i < 8; i++) begin
            tick(i == 7, pattern[i]);
            user_bits[i] = pre_tdo;
        end
        check("user_capture", 32'(user_bits), 32'h3C);
        tick(1'b1, 1'b0);
        check("user_pre_upd.user_update", 32'(user_update), 32'd0);
        check("user_pre_upd.user_out",    32'(user_out),    32'd0);
        tick(1'b0, 1'b0);
        check("user_upd.user_out",    32'(user_out),    32'hA5);
        check("user_upd.user_update", 32'(user_update), 32'd1);
        tick(1'b0, 1'b0);
        check("user_post.user_update", 32'(user_update), 32'd0);
        check("user_post.user_out",    32'(user_out),    32'hA5);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            user_in = 8'($urandom);
            tick(($urandom_range(0, 99) < 35), 1'($urandom));
            if ($urandom_range(0, 399) == 0) async_reset();
            if (n % 250 == 249) begin
                for (int k = 0; k < 5; k++) tick(1'b1, 1'($urandom));
                check("five_tms_tlr", 32'(state), 32'd15);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
